uart_echo_ctrl: RTL and testbench
=================================

# uart_echo_ctrl

Buffered echo controller between `uart_rx` and `uart_tx`, replacing the unbuffered rx/tx test controllers. It acknowledges every received byte, discards frame-errored bytes and queues good bytes in a FIFO. It drains the FIFO into the transmitter through the `ready`/`tdre` handshake, with optional CR→CR LF expansion. It also exports status for the 7-segment display.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `CNT_W`, 8: width of the saturating frame-error counter.
- `clk`  in  1  system clock (the 25 MHz divided clock at top level).
- `clr`  in  1  reset, asynchronous, active-low.
- `rdrf`  in  1  uart_rx receive-data-ready flag.
- `rx_data`  in  8  uart_rx received byte; valid while `rdrf`=1.
- `FE`  in  1  uart_rx frame error for the current byte; valid while `rdrf`=1.
- `rdrf_clr`  out  1  one-cycle pulse that clears `rdrf`.
- `tdre`  in  1  uart_tx transmit-buffer-empty flag.
- `ready`  out  1  one-cycle pulse that loads `tx_data` into uart_tx.
- `tx_data`  out  8  byte to transmit; registered, held until the next load.
- `crlf_en`  in  1  1 = insert 0x0A after every transmitted 0x0D.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when a good byte is dropped because the FIFO is full.
- `fe_count`  out  CNT_W  frame-error count; saturates at all-ones.
- `last_byte`  out  8  most recent byte written to the FIFO (display source).

## Operation
- Reset (`clr`=0, async): all outputs 0, FIFO empty, `lf_pending`=0, both FSMs idle.
- RX FSM states: R_IDLE, R_ACK.
  - R_IDLE with `rdrf`=1:
    - Pulse `rdrf_clr`.
    - If `FE`=1: drop the byte and increment `fe_count` (saturating).
    - Else if the FIFO is not full: push `rx_data` and update `last_byte`.
    - Else (FIFO full): drop the byte and set `overflow`.
    - Go to R_ACK.
  - R_ACK: stay while `rdrf`=1; return to R_IDLE when `rdrf`=0. Each byte is taken exactly once.
- TX FSM states: T_IDLE, T_WAIT.
  - T_IDLE with `tdre`=1 and (`lf_pending`=1 or FIFO not empty):
    - Pulse `ready`.
    - If `lf_pending`=1: `tx_data`=0x0A, clear `lf_pending`, no pop.
    - Otherwise: `tx_data`=FIFO head, pop. Set `lf_pending` if the popped byte is 0x0D and `crlf_en`=1.
    - Go to T_WAIT.
  - T_WAIT: stay while `tdre`=1; return to T_IDLE when `tdre`=0 (transmitter accepted the byte).
  - An inserted LF always goes out before the next FIFO byte.
- `crlf_en` is sampled at pop time. Changing it mid-stream affects only later pops; an already pending LF is still sent.
- FIFO full/empty decisions use occupancy at the start of the cycle.
  - Full: push is blocked even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full or empty: count unchanged.
  - Empty: no pop, even if a push happens in the same cycle.
- Read/write pointers wrap modulo DEPTH. `fifo_count` ranges 0..DEPTH.
- `overflow` clears only on reset.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `rdrf` sampled high at edge E0:
  - `rdrf_clr`=1 for the cycle after E0.
  - FIFO write and `last_byte` update occur at E0.
- Empty FIFO with `tdre`=1: `ready`/`tx_data` are driven at E1. Receive-to-load latency is 2 clocks.
- Back-to-back throughput is one byte per `tdre` high→low→high cycle of uart_tx.
- Reset asserted mid-transfer: an in-flight `ready`/`rdrf_clr` pulse is cut. Queued data and `lf_pending` are lost.

## Structure
- Package `uart_ctrl_pkg`:
  - RX and TX state enums.
  - Constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A.
  - Default DEPTH.
- Sub-module `sync_fifo`:
  - Parameters: DEPTH, width 8.
  - Ports: push, pop, din, dout (head, combinational read), full, empty, count.
  - Asynchronous active-low clear.
- Top-level FSMs, counters and the `lf_pending` flag live in `uart_echo_ctrl`.

## Test plan
- Reset, then byte 0x41 with `FE`=0 and `tdre`=1 → one `rdrf_clr` pulse; `ready` 2 clocks after `rdrf`; `tx_data`=0x41; `last_byte`=0x41; `fifo_count` returns to 0.
- Byte 0x55 with `FE`=1 → `rdrf_clr` pulses; no `ready`; `fe_count`=1. Repeat 300 frame-errored bytes with CNT_W=8 → `fe_count`=255.
- `tdre` held 0 and 18 good bytes 0x00..0x11 with DEPTH=16 → `fifo_count`=16, `overflow`=1. Releasing `tdre` transmits 0x00..0x0F in order, then the FIFO is empty.
- `crlf_en`=1, bytes 0x0D, 0x42 → transmitted 0x0D, 0x0A, 0x42. Same with `crlf_en`=0 → 0x0D, 0x42.
- Push and pop in the same cycle at `fifo_count`=DEPTH → pop happens, push is dropped, `overflow` is set. At a mid-level count → count unchanged.
- `clr` asserted while in T_WAIT with 5 bytes queued → all outputs 0 immediately; after release, no `ready` until a new byte arrives.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART echo controller.
package uart_ctrl_pkg;

  localparam int DEPTH_DEF = 16;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and registered occupancy.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the registered count, so both decisions use
  // start-of-cycle occupancy: a full FIFO refuses a push even if it pops.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Buffered echo controller: uart_rx -> FIFO -> uart_tx with optional CR->CRLF.
module uart_echo_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     rdrf,
  input  logic [7:0]               rx_data,
  input  logic                     FE,
  output logic                     rdrf_clr,
  input  logic                     tdre,
  output logic                     ready,
  output logic [7:0]               tx_data,
  input  logic                     crlf_en,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         fe_count,
  output logic [7:0]               last_byte
);

  rx_state_e  rx_st;
  tx_state_e  tx_st;
  logic       lf_pending;

  logic       f_full;
  logic       f_empty;
  logic [7:0] f_head;
  logic       rx_take;
  logic       f_push;
  logic       tx_go;
  logic       f_pop;

  // A byte is taken exactly once: only in R_IDLE, then we wait for rdrf to drop.
  assign rx_take = (rx_st == R_IDLE) && rdrf;
  assign f_push  = rx_take && !FE && !f_full;

  // A pending LF has priority over the FIFO head so it follows its CR directly.
  assign tx_go   = (tx_st == T_IDLE) && tdre && (lf_pending || !f_empty);
  assign f_pop   = tx_go && !lf_pending;

  sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (f_push),
    .pop   (f_pop),
    .din   (rx_data),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (fifo_count)
  );

  // Receive side: acknowledge, classify and count each incoming byte.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_st     <= R_IDLE;
      rdrf_clr  <= 1'b0;
      overflow  <= 1'b0;
      fe_count  <= '0;
      last_byte <= '0;
    end else begin
      rdrf_clr <= rx_take;
      case (rx_st)
        R_IDLE: begin
          if (rdrf) begin
            rx_st <= R_ACK;
            if (FE) begin
              if (fe_count != '1) fe_count <= fe_count + 1'b1;
            end else if (!f_full) begin
              last_byte <= rx_data;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        R_ACK:   if (!rdrf) rx_st <= R_IDLE;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // Transmit side: load one byte per tdre high->low->high cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tx_st      <= T_IDLE;
      ready      <= 1'b0;
      tx_data    <= '0;
      lf_pending <= 1'b0;
    end else begin
      ready <= tx_go;
      case (tx_st)
        T_IDLE: begin
          if (tx_go) begin
            tx_st <= T_WAIT;
            if (lf_pending) begin
              tx_data    <= ASCII_LF;
              lf_pending <= 1'b0;
            end else begin
              tx_data    <= f_head;
              // crlf_en is looked at only here, when the CR leaves the FIFO.
              lf_pending <= crlf_en && (f_head == ASCII_CR);
            end
          end
        end
        T_WAIT:  if (!tdre) tx_st <= T_IDLE;
        default: tx_st <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: expected tx bytes queued at stimulus,
// popped and compared by an independent monitor on every ready pulse.
module tb_uart_echo_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       rdrf;
  logic [7:0] rx_data;
  logic       FE;
  logic       rdrf_clr;
  logic       tdre;
  logic       ready;
  logic [7:0] tx_data;
  logic       crlf_en;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] fe_count;
  logic [7:0] last_byte;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       tx_gate;
  int         busy;

  always #5 clk = ~clk;

  uart_echo_ctrl #(.DEPTH(16), .CNT_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .rdrf       (rdrf),
    .rx_data    (rx_data),
    .FE         (FE),
    .rdrf_clr   (rdrf_clr),
    .tdre       (tdre),
    .ready      (ready),
    .tx_data    (tx_data),
    .crlf_en    (crlf_en),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .fe_count   (fe_count),
    .last_byte  (last_byte)
  );

  // Transmitter model: after a load it stays busy (tdre=0) for a few cycles.
  assign tdre = tx_gate && (busy == 0);

  always @(negedge clk) begin
    if (!clr)          busy = 0;
    else if (ready)    busy = 3;
    else if (busy > 0) busy = busy - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every load pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got tx_data %0h expected no load at %0t", tx_data, $time);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp_b});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic fe);
    int n;
    @(negedge clk);
    rdrf = 1'b1; rx_data = b; FE = fe;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (rdrf_clr === 1'b1) break;
      if (n > 20) begin
        total++; bad++;
        $display("FAIL rdrf_clr_timeout: got no pulse expected pulse for byte %0h", b);
        break;
      end
    end
    rdrf = 1'b0; FE = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    chk("fifo_empty", fifo_count, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},    ready, 0);
    chk({tag, "_rdrf_clr"}, rdrf_clr, 0);
    chk({tag, "_tx_data"},  tx_data, 0);
    chk({tag, "_count"},    fifo_count, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_fe_count"}, fe_count, 0);
    chk({tag, "_last"},     last_byte, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr = 1'b0; rdrf = 1'b0; rx_data = 8'h00; FE = 1'b0;
    crlf_en = 1'b0; tx_gate = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    clr = 1'b1;
    repeat (2) @(negedge clk);

    // Single good byte: rdrf_clr one cycle after sampling, ready one later.
    rdrf = 1'b1; rx_data = 8'h41; FE = 1'b0;
    exp_q.push_back(8'h41);
    @(negedge clk);
    chk("t1_rdrf_clr", rdrf_clr, 1);
    chk("t1_last", last_byte, 8'h41);
    rdrf = 1'b0;
    @(negedge clk);
    chk("t1_ready_lat", ready, 1);
    chk("t1_rdrf_clr_pulse", rdrf_clr, 0);
    drain();

    // Frame errors: counted, never transmitted, saturate at 255.
    send_byte(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    chk("fe_one", fe_count, 1);
    chk("fe_last_kept", last_byte, 8'h41);
    for (int i = 0; i < 300; i++) send_byte(8'h55, 1'b1);
    @(negedge clk);
    chk("fe_sat", fe_count, 255);

    // Overflow: 18 bytes into a blocked transmitter, first 16 survive.
    tx_gate = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b0);
    end
    @(negedge clk);
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_last", last_byte, 8'h0F);
    tx_gate = 1'b1;
    drain();
    chk("ovf_sticky", overflow, 1);

    // CR expansion on, then off.
    crlf_en = 1'b1;
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); exp_q.push_back(8'h42);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h42, 1'b0);
    drain();
    crlf_en = 1'b0;
    exp_q.push_back(8'h0D); exp_q.push_back(8'h42);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h42, 1'b0);
    drain();

    // Push and pop in the same cycle with the FIFO full.
    do_reset();
    tx_gate = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_byte(8'h20 + 8'(i), 1'b0);
    end
    @(negedge clk);
    chk("full_count", fifo_count, 16);
    chk("full_no_ovf", overflow, 0);
    tx_gate = 1'b1; rdrf = 1'b1; rx_data = 8'h99; FE = 1'b0;
    @(negedge clk);
    chk("full_pp_count", fifo_count, 15);
    chk("full_pp_ovf", overflow, 1);
    chk("full_pp_last", last_byte, 8'h2F);
    rdrf = 1'b0;
    drain();

    // Push and pop in the same cycle at a mid-level count.
    tx_gate = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      send_byte(8'h30 + 8'(i), 1'b0);
    end
    @(negedge clk);
    chk("mid_count", fifo_count, 4);
    exp_q.push_back(8'h34);
    tx_gate = 1'b1; rdrf = 1'b1; rx_data = 8'h34; FE = 1'b0;
    @(negedge clk);
    chk("mid_pp_count", fifo_count, 4);
    chk("mid_pp_last", last_byte, 8'h34);
    rdrf = 1'b0;
    drain();

    // Reset while waiting on the transmitter with 5 bytes still queued.
    do_reset();
    tx_gate = 1'b0;
    exp_q.push_back(8'h60);
    for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i), 1'b0);
    tx_gate = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) break;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL rst_ready_timeout: got no load expected load");
        break;
      end
    end
    #2 clr = 1'b0;
    #1 chk_zero("midrst");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_count", fifo_count, 0);
    exp_q.push_back(8'h77);
    send_byte(8'h77, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
